// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control unit: opcodes, state
// encoding, datapath mux select values and the packed control word.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_JUMP  = 5'd24;
  localparam logic [4:0] OP_BEQZ  = 5'd25;
  localparam logic [4:0] OP_LOAD  = 5'd28;
  localparam logic [4:0] OP_STORE = 5'd29;
  localparam logic [4:0] OP_LOADI = 5'd30;
  localparam logic [4:0] OP_HALT  = 5'd31;

  localparam int ZERO_FLAG_BIT = 0;

  localparam logic [1:0] PC_SEL_INC   = 2'd0;
  localparam logic [1:0] PC_SEL_IMM   = 2'd1;
  localparam logic [1:0] PC_SEL_ALU   = 2'd2;

  localparam logic [1:0] ADDR_SEL_PC  = 2'd0;
  localparam logic [1:0] ADDR_SEL_ALU = 2'd1;
  localparam logic [1:0] ADDR_SEL_IMM = 2'd2;

  localparam logic [1:0] DIN_SEL_ALU  = 2'd0;
  localparam logic [1:0] DIN_SEL_MEM  = 2'd1;
  localparam logic [1:0] DIN_SEL_IMM  = 2'd2;

  // Codes 11..15 are unused and fall back to FETCH.
  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_EXEC    = 4'd2,
    ST_WB      = 4'd3,
    ST_LOADI   = 4'd4,
    ST_STORE   = 4'd5,
    ST_LOAD_A  = 4'd6,
    ST_LOAD_W  = 4'd7,
    ST_JUMP    = 4'd8,
    ST_BRANCH  = 4'd9,
    ST_HALT    = 4'd10
  } state_e;

  typedef struct packed {
    logic       alu_in2_mux;
    logic       mem_out_mux;
    logic [1:0] pc_mux;
    logic [1:0] memory_addr_mux;
    logic [1:0] data_in_mux;
    logic       reg_buff1_write;
    logic       reg_buff2_write;
    logic       status_reg_write;
    logic       alu_out_write;
    logic       reg_write;
    logic       pc_write;
    logic       ir_write;
    logic       mem_write;
    logic       halted;
    logic       illegal_op;
  } ctrl_word_t;

  // Opcodes 0..15 are the ALU group (reg-reg and reg-immediate).
  function automatic logic is_alu_op(input logic [4:0] op);
    return ~op[4];
  endfunction

  function automatic logic is_defined_op(input logic [4:0] op);
    return is_alu_op(op) || (op == OP_JUMP) || (op == OP_BEQZ) ||
           (op == OP_LOAD) || (op == OP_STORE) || (op == OP_LOADI) ||
           (op == OP_HALT);
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bus between the control unit (master) and the datapath (slave).
interface control_unit_if #(
  parameter int WORD_SIZE   = 16,
  parameter int OPCODE_SIZE = 5
);
  logic [OPCODE_SIZE-1:0] opcode;
  logic [WORD_SIZE-1:0]   status_reg;
  logic                   ALU_in2_mux;
  logic                   mem_out_mux;
  logic [1:0]             PC_mux;
  logic [1:0]             memory_addr_mux;
  logic [1:0]             data_in_mux;
  logic                   reg_buff1_write;
  logic                   reg_buff2_write;
  logic                   status_reg_write;
  logic                   ALU_out_write;
  logic                   reg_write;
  logic                   PC_write;
  logic                   IR_write;
  logic                   mem_write;
  logic                   halted;
  logic                   illegal_op;

  modport master (
    input  opcode, status_reg,
    output ALU_in2_mux, mem_out_mux, PC_mux, memory_addr_mux, data_in_mux,
           reg_buff1_write, reg_buff2_write, status_reg_write, ALU_out_write,
           reg_write, PC_write, IR_write, mem_write, halted, illegal_op
  );

  modport slave (
    output opcode, status_reg,
    input  ALU_in2_mux, mem_out_mux, PC_mux, memory_addr_mux, data_in_mux,
           reg_buff1_write, reg_buff2_write, status_reg_write, ALU_out_write,
           reg_write, PC_write, IR_write, mem_write, halted, illegal_op
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational decode of the current state into the datapath control word.
// Only DECODE (illegal_op), EXEC (ALU_in2_mux) and BRANCH (PC_write) look
// beyond the state itself.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int WORD_SIZE   = 16,
  parameter int OPCODE_SIZE = 5,
  parameter int ZFLAG_BIT   = 0
) (
  input  state_e                 state,
  input  logic [OPCODE_SIZE-1:0] opcode,
  input  logic [WORD_SIZE-1:0]   status_reg,
  output ctrl_word_t             cw
);

  // Everything defaults to zero; each state lists only what it asserts.
  always_comb begin
    cw = '0;
    case (state)
      ST_FETCH: begin
        cw.memory_addr_mux = ADDR_SEL_PC;
        cw.ir_write        = 1'b1;
        cw.pc_mux          = PC_SEL_INC;
        cw.pc_write        = 1'b1;
      end
      ST_DECODE: begin
        cw.reg_buff1_write = 1'b1;
        cw.reg_buff2_write = 1'b1;
        cw.illegal_op      = ~is_defined_op(opcode);
      end
      ST_EXEC: begin
        cw.alu_in2_mux      = (opcode < OPCODE_SIZE'(8));
        cw.alu_out_write    = 1'b1;
        cw.status_reg_write = 1'b1;
      end
      ST_WB: begin
        cw.data_in_mux = DIN_SEL_ALU;
        cw.reg_write   = 1'b1;
      end
      ST_LOADI: begin
        cw.data_in_mux = DIN_SEL_IMM;
        cw.reg_write   = 1'b1;
      end
      ST_STORE: begin
        cw.memory_addr_mux = ADDR_SEL_IMM;
        cw.mem_out_mux     = 1'b0;
        cw.mem_write       = 1'b1;
      end
      ST_LOAD_A: begin
        cw.memory_addr_mux = ADDR_SEL_IMM;
      end
      ST_LOAD_W: begin
        cw.memory_addr_mux = ADDR_SEL_IMM;
        cw.data_in_mux     = DIN_SEL_MEM;
        cw.reg_write       = 1'b1;
      end
      ST_JUMP: begin
        cw.pc_mux   = PC_SEL_IMM;
        cw.pc_write = 1'b1;
      end
      ST_BRANCH: begin
        cw.pc_mux   = PC_SEL_IMM;
        cw.pc_write = status_reg[ZFLAG_BIT];
      end
      ST_HALT: begin
        cw.halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM for the 16-bit CPU: holds the state register and
// next-state logic, and drives the datapath control bus via ctrl_decode.
module control_unit #(
  parameter int WORD_SIZE     = 16,
  parameter int OPCODE_SIZE   = 5,
  parameter int ZERO_FLAG_BIT = cpu_ctrl_pkg::ZERO_FLAG_BIT
) (
  input  logic           clk,
  input  logic           rst,
  control_unit_if.master bus
);
  import cpu_ctrl_pkg::*;

  state_e     state_q, state_d;
  ctrl_word_t cw;
  ctrl_word_t cw_out;

  ctrl_decode #(
    .WORD_SIZE  (WORD_SIZE),
    .OPCODE_SIZE(OPCODE_SIZE),
    .ZFLAG_BIT  (ZERO_FLAG_BIT)
  ) u_decode (
    .state     (state_q),
    .opcode    (bus.opcode),
    .status_reg(bus.status_reg),
    .cw        (cw)
  );

  // Next-state: opcode dispatch happens only in DECODE; unused codes recover to FETCH.
  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        if (is_alu_op(bus.opcode)) begin
          state_d = ST_EXEC;
        end else begin
          case (bus.opcode)
            OP_JUMP:  state_d = ST_JUMP;
            OP_BEQZ:  state_d = ST_BRANCH;
            OP_LOAD:  state_d = ST_LOAD_A;
            OP_STORE: state_d = ST_STORE;
            OP_LOADI: state_d = ST_LOADI;
            OP_HALT:  state_d = ST_HALT;
            default:  state_d = ST_FETCH;
          endcase
        end
      end
      ST_EXEC:   state_d = ST_WB;
      ST_LOAD_A: state_d = ST_LOAD_W;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase
  end

  // State register; reset parks the FSM in FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  // While reset is held the FETCH decode must not leak out, so the whole word is forced to zero.
  always_comb begin
    cw_out = rst ? '0 : cw;
  end

  assign bus.ALU_in2_mux      = cw_out.alu_in2_mux;
  assign bus.mem_out_mux      = cw_out.mem_out_mux;
  assign bus.PC_mux           = cw_out.pc_mux;
  assign bus.memory_addr_mux  = cw_out.memory_addr_mux;
  assign bus.data_in_mux      = cw_out.data_in_mux;
  assign bus.reg_buff1_write  = cw_out.reg_buff1_write;
  assign bus.reg_buff2_write  = cw_out.reg_buff2_write;
  assign bus.status_reg_write = cw_out.status_reg_write;
  assign bus.ALU_out_write    = cw_out.alu_out_write;
  assign bus.reg_write        = cw_out.reg_write;
  assign bus.PC_write         = cw_out.pc_write;
  assign bus.IR_write         = cw_out.ir_write;
  assign bus.mem_write        = cw_out.mem_write;
  assign bus.halted           = cw_out.halted;
  assign bus.illegal_op       = cw_out.illegal_op;

endmodule
